// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Holds bus widths, the exception codes the controller cares about, the
// stall-vector constants and the FSM state encoding.
package pipeline_ctrl_pkg;

  localparam int EXC_TYPE_W = 5;   // exception code width
  localparam int DATA_W     = 32;  // data bus width (EPC)
  localparam int ADDR_W     = 32;  // address bus width (redirect PC)
  localparam int STALL_W    = 6;   // PC, IF, ID, EX, MEM, WB

  localparam logic [EXC_TYPE_W-1:0] EXC_NONE = 5'h00;
  localparam logic [EXC_TYPE_W-1:0] EXC_ERET = 5'h0E;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    PCTRL_IDLE      = 2'd0,
    PCTRL_WAIT_IBUS = 2'd1,
    PCTRL_FLUSH     = 2'd2
  } pctrl_state_e;

  // True when the MEM-stage exception code is a return-from-exception.
  function automatic logic is_eret(input logic [EXC_TYPE_W-1:0] exc);
    return (exc == EXC_ERET);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Priority encoder from per-stage stall requests to the per-register
// stall vector. The deepest requesting stage wins; every register up to and
// including that stage is held. WB is never stalled by a request.
// Ports:
//   stall_req_if/id/ex/mem : per-stage stall requests
//   stall_vec              : 6-bit vector, [0]=PC ... [5]=WB
module pipeline_ctrl_stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic               stall_req_if,
  input  logic               stall_req_id,
  input  logic               stall_req_ex,
  input  logic               stall_req_mem,
  output logic [STALL_W-1:0] stall_vec
);

  // Deepest request selects the vector; shallower ones are subsumed by it.
  always_comb begin
    stall_vec = STALL_NONE;
    if (stall_req_mem) begin
      stall_vec = STALL_MEM;
    end else if (stall_req_ex) begin
      stall_vec = STALL_EX;
    end else if (stall_req_id) begin
      stall_vec = STALL_ID;
    end else if (stall_req_if) begin
      stall_vec = STALL_IF;
    end else begin
      stall_vec = STALL_NONE;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline registers.
// Merges stage stall requests, turns MEM-stage exceptions/ERET into a
// one-cycle flush with PC redirect (deferred while an instruction-bus
// transaction is outstanding), and counts stalled cycles.
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   stall_req_*         : per-stage stall requests
//   exception_type      : MEM-stage exception code, 0 = none
//   cp0_epc             : EPC, target for ERET
//   ibus_busy           : instruction-bus transaction outstanding
//   stall               : registered stall vector, [0]=PC ... [5]=WB
//   flush               : registered flush-all pulse
//   redirect_pc         : new PC, non-zero only while flush=1
//   stall_cycles        : saturating count of cycles with stall[0]=1
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380,
  parameter int                CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic [EXC_TYPE_W-1:0] exception_type,
  input  logic [DATA_W-1:0]     cp0_epc,
  input  logic                  ibus_busy,
  output logic [STALL_W-1:0]    stall,
  output logic                  flush,
  output logic [ADDR_W-1:0]     redirect_pc,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pctrl_state_e       state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               flush_q, flush_d;
  logic [ADDR_W-1:0]  redirect_q, redirect_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_enc_s;

  pipeline_ctrl_stall_encoder u_stall_encoder (
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .stall_vec     (stall_enc_s)
  );

  // Next-state and next-output decode. Outputs are registered, so each
  // branch computes what the pipeline sees during the state being entered.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    stall_d    = STALL_NONE;
    flush_d    = 1'b0;
    redirect_d = {ADDR_W{1'b0}};
    case (state_q)
      PCTRL_IDLE: begin
        if (exception_type != EXC_NONE) begin
          // EPC is captured in the same cycle the exception is decided.
          target_d = is_eret(exception_type) ? cp0_epc : EXC_VECTOR;
          if (ibus_busy) begin
            // Freeze everything, including MEM/WB, so the faulting
            // instruction stays in MEM without a bubble.
            state_d = PCTRL_WAIT_IBUS;
            stall_d = STALL_ALL;
          end else begin
            state_d    = PCTRL_FLUSH;
            flush_d    = 1'b1;
            redirect_d = target_d;
          end
        end else begin
          state_d = PCTRL_IDLE;
          stall_d = stall_enc_s;
        end
      end
      PCTRL_WAIT_IBUS: begin
        if (ibus_busy) begin
          state_d = PCTRL_WAIT_IBUS;
          stall_d = STALL_ALL;
        end else begin
          state_d    = PCTRL_FLUSH;
          flush_d    = 1'b1;
          redirect_d = target_q;
        end
      end
      PCTRL_FLUSH: begin
        // Inputs seen during the flush cycle belong to killed instructions.
        state_d = PCTRL_IDLE;
      end
      default: begin
        state_d = PCTRL_IDLE;
      end
    endcase
  end

  // Saturating stall-cycle counter driven by the registered stall[0].
  always_comb begin
    cnt_d = cnt_q;
    if (stall_q[0] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PCTRL_IDLE;
      stall_q    <= STALL_NONE;
      flush_q    <= 1'b0;
      redirect_q <= {ADDR_W{1'b0}};
      target_q   <= {ADDR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall        = stall_q;
  assign flush        = flush_q;
  assign redirect_pc  = redirect_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes reference-model
// expectations into a queue, a monitor pops and compares every cycle.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam logic [31:0] VEC   = 32'hBFC00380;
  localparam longint      MAX32 = 64'd4294967295;
  localparam longint      MAX4  = 64'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  req_if, req_id, req_ex, req_mem;
  logic [EXC_TYPE_W-1:0] exc;
  logic [31:0]           epc;
  logic                  busy;

  logic [5:0]  stall, stall4;
  logic        flush, flush4;
  logic [31:0] redirect, redirect4;
  logic [31:0] cyc32;
  logic [3:0]  cyc4;

  pipeline_ctrl #(.EXC_VECTOR(VEC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stall_req_if(req_if), .stall_req_id(req_id),
    .stall_req_ex(req_ex), .stall_req_mem(req_mem),
    .exception_type(exc), .cp0_epc(epc), .ibus_busy(busy),
    .stall(stall), .flush(flush), .redirect_pc(redirect),
    .stall_cycles(cyc32)
  );

  pipeline_ctrl #(.EXC_VECTOR(VEC), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .stall_req_if(req_if), .stall_req_id(req_id),
    .stall_req_ex(req_ex), .stall_req_mem(req_mem),
    .exception_type(exc), .cp0_epc(epc), .ibus_busy(busy),
    .stall(stall4), .flush(flush4), .redirect_pc(redirect4),
    .stall_cycles(cyc4)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    longint      c32;
    longint      c4;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_wait;
  bit          m_after_flush;
  logic [31:0] m_target;
  logic [5:0]  m_stall;
  longint      m_c32, m_c4;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Compute what the outputs must be after the coming rising edge.
  function automatic void model_step();
    exp_t e;
    int   depth;
    e.stall = 6'd0; e.flush = 1'b0; e.pc = 32'd0;
    if (!rst) begin
      m_wait = 0; m_after_flush = 0; m_target = 32'd0;
      m_stall = 6'd0; m_c32 = 0; m_c4 = 0;
    end else begin
      if (m_stall[0]) begin
        if (m_c32 < MAX32) m_c32++;
        if (m_c4 < MAX4) m_c4++;
      end
      if (m_after_flush) begin
        m_after_flush = 0;
      end else if (m_wait) begin
        if (busy) e.stall = 6'b111111;
        else begin
          m_wait = 0; m_after_flush = 1; e.flush = 1'b1; e.pc = m_target;
        end
      end else if (exc != 0) begin
        m_target = (exc == EXC_ERET) ? epc : VEC;
        if (busy) begin
          m_wait = 1; e.stall = 6'b111111;
        end else begin
          m_after_flush = 1; e.flush = 1'b1; e.pc = m_target;
        end
      end else begin
        depth = req_mem ? 4 : req_ex ? 3 : req_id ? 2 : req_if ? 1 : 0;
        if (depth > 0) e.stall = 6'((1 << (depth + 1)) - 1);
      end
      m_stall = e.stall;
    end
    e.c32 = m_c32;
    e.c4  = m_c4;
    q.push_back(e);
  endfunction

  task automatic step(input logic r, input logic [3:0] reqs,
                      input logic [EXC_TYPE_W-1:0] x, input logic [31:0] p,
                      input logic b);
    @(negedge clk);
    rst = r;
    {req_mem, req_ex, req_id, req_if} = reqs;
    exc = x; epc = p; busy = b;
    model_step();
  endtask

  // Monitor: one expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {58'd0, stall}, {58'd0, e.stall});
        chk("flush", {63'd0, flush}, {63'd0, e.flush});
        chk("redirect_pc", {32'd0, redirect}, {32'd0, e.pc});
        chk("stall_cycles32", {32'd0, cyc32}, e.c32);
        chk("stall_cycles4", {60'd0, cyc4}, e.c4);
      end
    end
  end

  initial begin
    rst = 1'b0; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
    exc = '0; epc = 32'd0; busy = 1'b0;
    m_wait = 0; m_after_flush = 0; m_target = 0; m_stall = 0; m_c32 = 0; m_c4 = 0;

    step(1'b0, 4'b0000, 5'd0, 32'd0, 1'b0);
    step(1'b0, 4'b0000, 5'd0, 32'd0, 1'b0);

    // Stall priority: ID + MEM for 3 cycles, then IF only
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1010, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0001, 5'd0, 32'd0, 1'b0);
    step(1'b1, 4'b0000, 5'd0, 32'd0, 1'b0);

    // Normal exception with idle bus
    step(1'b1, 4'b0110, 5'h04, 32'h12345678, 1'b0);
    @(posedge clk); #1;
    chk("exc_flush", {63'd0, flush}, 64'd1);
    chk("exc_vector", {32'd0, redirect}, {32'd0, VEC});
    step(1'b1, 4'b0000, 5'd0, 32'd0, 1'b0);
    step(1'b1, 4'b0000, 5'd0, 32'd0, 1'b0);

    // ERET
    step(1'b1, 4'b0000, EXC_ERET, 32'h80001234, 1'b0);
    @(posedge clk); #1;
    chk("eret_target", {32'd0, redirect}, 64'h80001234);
    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b0);
    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b0);

    // Deferred flush: busy held 4 cycles, MEM stall during wait ignored
    step(1'b1, 4'b0000, 5'h0C, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1000, EXC_ERET, 32'hDEADBEE0, 1'b1);
    step(1'b1, 4'b1000, 5'd0, 32'h0, 1'b0);
    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b0);
    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b0);

    // Reset mid-WAIT_IBUS takes effect immediately, no flush after release
    step(1'b1, 4'b0000, 5'h04, 32'h0, 1'b1);
    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b1);
    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b1);
    step(1'b0, 4'b0000, 5'd0, 32'h0, 1'b1);
    #1;
    chk("async_rst_stall", {58'd0, stall}, 64'd0);
    chk("async_rst_flush", {63'd0, flush}, 64'd0);
    chk("async_rst_cnt", {32'd0, cyc32}, 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b0);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0001, 5'd0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("sat4", {60'd0, cyc4}, 64'd15);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [EXC_TYPE_W-1:0] x;
      x = 5'd0;
      if ($urandom_range(0, 7) == 0)
        x = ($urandom_range(0, 1) == 1) ? EXC_ERET : 5'($urandom_range(1, 31));
      step(($urandom_range(0, 299) != 0), 4'($urandom), x, $urandom,
           ($urandom_range(0, 1) == 1));
    end

    step(1'b1, 4'b0000, 5'd0, 32'h0, 1'b0);
    @(posedge clk); #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
